// File: rtl/consmax_lut_loader_if.sv
// Upstream LUT configuration stream for consmax_lut_loader.
// The configuration source drives the master side; the loader is the slave.
interface consmax_lut_loader_if #(
    parameter int LUT_DATA = 16
);
    logic [LUT_DATA-1:0] in_data;
    logic                in_valid;
    logic                in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

// File: rtl/consmax_lut_loader.sv
// consmax_lut_loader: sequences LUT words from a valid/ready configuration
// stream into the two INT-to-FP lookup tables of the ConSmax softmax block.
// One registered LUT write is issued per accepted word; busy holds off ConSmax
// data traffic while a load is in flight and done pulses once it completes.
//
// Optional feature macro: CONSMAX_LUT_CHECKSUM_EN
//   defined   -> a wrapping checksum of the loaded words is compared against a
//                trailer word taken after the data; a mismatch raises sticky err.
//   undefined -> no trailer is consumed and err is tied low.
module consmax_lut_loader #(
    parameter int LUT_ADDR = 4,
    parameter int LUT_DATA = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LUT_ADDR:0]   cfg_base,
    input  logic [LUT_ADDR+1:0] cfg_len,
    consmax_lut_loader_if.slave cfg_in,
    output logic [LUT_ADDR:0]   lut_waddr,
    output logic                lut_wen,
    output logic [LUT_DATA-1:0] lut_wdata,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int AW    = LUT_ADDR + 1;
    localparam int LEN_W = LUT_ADDR + 2;
    // Both LUTs together: the largest meaningful load length.
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(2 ** AW);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [AW-1:0]    ADDR_ONE = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [AW-1:0]       addr_r;
    logic [LEN_W-1:0]    rem_r;
    logic [AW-1:0]       waddr_r;
    logic [LUT_DATA-1:0] wdata_r;
    logic                wen_r;
    logic                done_r;
    logic                in_ready_s;
    logic                beat_s;
    logic                busy_s;
    logic                done_set_s;
    logic [LEN_W-1:0]    len_clamp_s;

`ifdef CONSMAX_LUT_CHECKSUM_EN
    logic [LUT_DATA-1:0] sum_r;
    logic                err_r;
    // Set once the trailer is taken, so FIN knows done has already been issued.
    logic                trl_seen_r;

    // Wrapping LUT_DATA-bit checksum accumulate.
    function automatic logic [LUT_DATA-1:0] csum_add(
        input logic [LUT_DATA-1:0] acc,
        input logic [LUT_DATA-1:0] word
    );
        return acc + word;
    endfunction
`endif

    // Next-state, handshake readiness and busy/done decode from the current state.
    always_comb begin
        state_next_s = state_r;
        in_ready_s   = 1'b0;
        busy_s       = 1'b0;
        done_set_s   = 1'b0;
        if (cfg_len > LEN_MAX) begin
            len_clamp_s = LEN_MAX;
        end else begin
            len_clamp_s = cfg_len;
        end
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (len_clamp_s == LEN_ZERO) begin
                        state_next_s = ST_FIN;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
                if (cfg_in.in_valid && (rem_r == LEN_ONE)) begin
`ifdef CONSMAX_LUT_CHECKSUM_EN
                    state_next_s = ST_CHECK;
`else
                    state_next_s = ST_FIN;
`endif
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_CHECK: begin
`ifdef CONSMAX_LUT_CHECKSUM_EN
                in_ready_s = 1'b1;
                busy_s     = 1'b1;
                if (cfg_in.in_valid) begin
                    // done is raised right behind the trailer; FIN is then quiet.
                    state_next_s = ST_FIN;
                    done_set_s   = 1'b1;
                end else begin
                    state_next_s = ST_CHECK;
                end
`else
                state_next_s = ST_IDLE;
`endif
            end
            ST_FIN: begin
                state_next_s = ST_IDLE;
`ifdef CONSMAX_LUT_CHECKSUM_EN
                busy_s     = ~trl_seen_r;
                done_set_s = ~trl_seen_r;
`else
                // FIN carries the final write, so busy still covers it.
                busy_s     = 1'b1;
                done_set_s = 1'b1;
`endif
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign beat_s = cfg_in.in_valid & in_ready_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Address/length counters and the registered LUT write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r  <= {AW{1'b0}};
            rem_r   <= LEN_ZERO;
            waddr_r <= {AW{1'b0}};
            wdata_r <= {LUT_DATA{1'b0}};
            wen_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            wen_r  <= 1'b0;
            done_r <= done_set_s;
            if ((state_r == ST_IDLE) && start) begin
                addr_r <= cfg_base;
                rem_r  <= len_clamp_s;
            end else if ((state_r == ST_LOAD) && beat_s) begin
                wen_r   <= 1'b1;
                waddr_r <= addr_r;
                wdata_r <= cfg_in.in_data;
                // Natural wrap lets a load run from LUT1 back into LUT0.
                addr_r  <= addr_r + ADDR_ONE;
                rem_r   <= rem_r - LEN_ONE;
            end else begin
                addr_r <= addr_r;
                rem_r  <= rem_r;
            end
        end
    end

`ifdef CONSMAX_LUT_CHECKSUM_EN
    // Running checksum, trailer comparison and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r      <= {LUT_DATA{1'b0}};
            err_r      <= 1'b0;
            trl_seen_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            sum_r      <= {LUT_DATA{1'b0}};
            err_r      <= 1'b0;
            trl_seen_r <= 1'b0;
        end else if ((state_r == ST_LOAD) && beat_s) begin
            sum_r <= csum_add(sum_r, cfg_in.in_data);
        end else if ((state_r == ST_CHECK) && beat_s) begin
            err_r      <= (cfg_in.in_data != sum_r);
            trl_seen_r <= 1'b1;
        end else begin
            sum_r      <= sum_r;
            err_r      <= err_r;
            trl_seen_r <= trl_seen_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    assign cfg_in.in_ready = in_ready_s;
    assign lut_waddr       = waddr_r;
    assign lut_wdata       = wdata_r;
    assign lut_wen         = wen_r;
    assign busy            = busy_s;
    assign done            = done_r;
endmodule

// File: tb/tb_consmax_lut_loader.sv
// Scoreboard bench for consmax_lut_loader: the stimulus thread computes every
// expected LUT write (address = base + i mod 32, data = sent word) and the
// expected completion, and a monitor thread checks them as the DUT emits them.
module tb_consmax_lut_loader;
    localparam int LA   = 4;
    localparam int LD   = 16;
    localparam int NMAX = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [LA:0]   cfg_base;
    logic [LA+1:0] cfg_len;
    logic [LA:0]   lut_waddr;
    logic          lut_wen;
    logic [LD-1:0] lut_wdata;
    logic          busy;
    logic          done;
    logic          err;

    consmax_lut_loader_if #(.LUT_DATA(LD)) cfg_if ();

    consmax_lut_loader #(.LUT_ADDR(LA), .LUT_DATA(LD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .cfg_in    (cfg_if),
        .lut_waddr (lut_waddr),
        .lut_wen   (lut_wen),
        .lut_wdata (lut_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [LA:0] addr; logic [LD-1:0] data; } wr_t;
    typedef struct packed { logic err; logic gap_chk; } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_wen_cyc = -10;
    int wen_total = 0;
    int done_total = 0;
    int run_cnt = 0;
    int last_run = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic monitor();
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            cyc++;
            if (lut_wen === 1'b1) begin
                wen_total++;
                run_cnt++;
                check("busy_during_write", 32'(busy), 32'd1);
                check("write_expected", 32'(wq.size() > 0), 32'd1);
                if (wq.size() > 0) begin
                    w = wq.pop_front();
                    check("write_addr", 32'(lut_waddr), 32'(w.addr));
                    check("write_data", 32'(lut_wdata), 32'(w.data));
                end
                last_wen_cyc = cyc;
            end else begin
                if (run_cnt > 0) last_run = run_cnt;
                run_cnt = 0;
            end
            if (done === 1'b1) begin
                done_total++;
                check("done_expected", 32'(dq.size() > 0), 32'd1);
                check("busy_low_at_done", 32'(busy), 32'd0);
                if (dq.size() > 0) begin
                    d = dq.pop_front();
                    check("done_err", 32'(err), 32'(d.err));
                    if (d.gap_chk) check("done_after_last_write", 32'(cyc), 32'(last_wen_cyc + 1));
                end
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    // mode: 0 back-to-back, 1 valid toggling 1,0,1,0, 2 random bubbles.
    task automatic run_load(input int base, input int len, input int mode, input bit ign, input bit ramp);
        int n, sent, tries, wen0, done0;
        bit v, tog;
        logic [LD-1:0] w;
        wr_t e;
        dn_t d;
`ifdef CONSMAX_LUT_CHECKSUM_EN
        logic [LD-1:0] sum;
        bit corrupt, acc;
        sum = '0;
`endif
        n = (len > NMAX) ? NMAX : len;
        wen0 = wen_total;
        done0 = done_total;
        start = 1'b1;
        cfg_base = 5'(base);
        cfg_len = 6'(len);
        @(negedge clk);
        start = 1'b0;
        cfg_base = 5'($urandom);
        cfg_len = 6'($urandom);
        check("err_clear_on_start", 32'(err), 32'd0);
        if (n > 0) begin
            check("busy_after_start", 32'(busy), 32'd1);
            check("ready_after_start", 32'(cfg_if.in_ready), 32'd1);
        end else begin
            check("zero_len_not_ready", 32'(cfg_if.in_ready), 32'd0);
        end
        sent = 0;
        tries = 0;
        tog = 1'b1;
        while (sent < n && tries < 400) begin
            case (mode)
                0: v = 1'b1;
                1: begin v = tog; tog = ~tog; end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            start = (ign && sent == 2) ? 1'b1 : 1'b0;
            w = ramp ? (16'h3F80 + 16'(sent)) : 16'($urandom);
            cfg_if.in_valid = v;
            cfg_if.in_data = w;
            if (v && cfg_if.in_ready) begin
                e.addr = 5'(base + sent);
                e.data = w;
                wq.push_back(e);
`ifdef CONSMAX_LUT_CHECKSUM_EN
                sum = sum + w;
`endif
                sent++;
            end
            tries++;
            @(negedge clk);
        end
        cfg_if.in_valid = 1'b0;
        start = 1'b0;
        check("beats_accepted", sent, n);
`ifdef CONSMAX_LUT_CHECKSUM_EN
        if (n > 0) begin
            corrupt = ($urandom_range(0, 1) == 1);
            d.err = corrupt;
            d.gap_chk = 1'b0;
            dq.push_back(d);
            acc = 1'b0;
            tries = 0;
            while (!acc && tries < 50) begin
                cfg_if.in_valid = 1'b1;
                cfg_if.in_data = corrupt ? (sum + 16'd1) : sum;
                if (cfg_if.in_ready) acc = 1'b1;
                tries++;
                @(negedge clk);
            end
            cfg_if.in_valid = 1'b0;
            check("trailer_accepted", 32'(acc), 32'd1);
        end else begin
            d.err = 1'b0;
            d.gap_chk = 1'b0;
            dq.push_back(d);
        end
`else
        d.err = 1'b0;
        d.gap_chk = (n > 0);
        dq.push_back(d);
`endif
        if (n == 0) begin
            @(negedge clk);
            check("zero_len_done_s2", 32'(done), 32'd1);
        end
        tries = 0;
        while (done_total == done0 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        repeat (2) @(negedge clk);
        check("done_count", done_total - done0, 1);
        check("write_count", wen_total - wen0, n);
        if (mode == 0 && n > 0) check("consecutive_writes", last_run, n);
    endtask

    // 8-word load interrupted by rst right after its 3rd write.
    task automatic reset_mid_load();
        int wen0, done0;
        wr_t e;
        wen0 = wen_total;
        done0 = done_total;
        start = 1'b1;
        cfg_base = 5'd0;
        cfg_len = 6'd8;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cfg_if.in_valid = 1'b1;
            cfg_if.in_data = 16'($urandom);
            e.addr = 5'(i);
            e.data = cfg_if.in_data;
            wq.push_back(e);
            @(negedge clk);
        end
        rst = 1'b1;
        cfg_if.in_data = 16'($urandom);
        @(negedge clk);
        rst = 1'b0;
        cfg_if.in_valid = 1'b0;
        check("mid_rst_wen", 32'(lut_wen), 32'd0);
        check("mid_rst_waddr", 32'(lut_waddr), 32'd0);
        check("mid_rst_wdata", 32'(lut_wdata), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        check("mid_rst_ready", 32'(cfg_if.in_ready), 32'd0);
        repeat (6) @(negedge clk);
        check("mid_rst_write_count", wen_total - wen0, 3);
        check("mid_rst_no_done", done_total - done0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_base = 5'd0;
        cfg_len = 6'd0;
        cfg_if.in_valid = 1'b0;
        cfg_if.in_data = 16'd0;
        fork
            monitor();
        join_none
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cfg_if.in_ready), 32'd0);
        check("rst_wen", 32'(lut_wen), 32'd0);
        check("rst_waddr", 32'(lut_waddr), 32'd0);
        check("rst_wdata", 32'(lut_wdata), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_load(0, 32, 0, 1'b0, 1'b1);   // full load, ramp 0x3F80..0x3F9F
        run_load(0, 4, 1, 1'b0, 1'b0);    // valid toggling 1,0,1,0
        run_load(30, 4, 0, 1'b0, 1'b0);   // wrap 1E,1F,00,01
        run_load(5, 0, 0, 1'b0, 1'b0);    // zero length
        run_load(8, 4, 0, 1'b1, 1'b0);    // start during load is ignored
        run_load(17, 45, 2, 1'b0, 1'b0);  // length clamped to 32
        reset_mid_load();
        run_load(3, 8, 0, 1'b0, 1'b0);    // normal load after reset
        for (int k = 0; k < 12; k++) begin
            run_load(int'($urandom_range(0, 31)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 2)), ($urandom_range(0, 1) == 1), 1'b0);
        end

        check("write_queue_drained", wq.size(), 0);
        check("done_queue_drained", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
